// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARM-subset CPU: sequences fetch/decode/execute,
// holds the NZCV flags and gates every commit with the latched condition result.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read registers, compute PC+8, latch condition
// MEMADR | address = Rn + imm
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write store data to memory
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to Rd (or PC)
// BRANCH | PC <= PC+8 + offset
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemW,
  output logic       IRWrite,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_exr;
  logic       cond_ex;
  logic [1:0] cmd_ctl;
  logic       pc_write, ir_write, reg_w, mem_w;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'h0: cond_ex = flags[2];
      4'h1: cond_ex = !flags[2];
      4'h2: cond_ex = flags[1];
      4'h3: cond_ex = !flags[1];
      4'h4: cond_ex = flags[3];
      4'h5: cond_ex = !flags[3];
      4'h6: cond_ex = flags[0];
      4'h7: cond_ex = !flags[0];
      4'h8: cond_ex = flags[1] && !flags[2];
      4'h9: cond_ex = !flags[1] || flags[2];
      4'hA: cond_ex = (flags[3] == flags[0]);
      4'hB: cond_ex = (flags[3] != flags[0]);
      4'hC: cond_ex = !flags[2] && (flags[3] == flags[0]);
      4'hD: cond_ex = flags[2] || (flags[3] != flags[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Unknown commands fall back to ADD, which also lets them update C and V.
  always_comb begin
    case (Funct[4:1])
      4'b0010: cmd_ctl = 2'b01;
      4'b0000: cmd_ctl = 2'b10;
      4'b1100: cmd_ctl = 2'b11;
      default: cmd_ctl = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= FETCH;
      flags    <= 4'b0000;
      cond_exr <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          cond_exr <= cond_ex;
          case (Op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= Funct[5] ? EXECI : EXECR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR, EXECI: begin
          state <= ALUWB;
          if (Funct[0] && cond_exr) begin
            flags[3:2] <= ALUFlags[3:2];
            if (!cmd_ctl[1]) flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = cond_exr;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = cond_exr;
      end
      EXECR: ALUControl = cmd_ctl;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd_ctl;
      end
      ALUWB: begin
        reg_w    = cond_exr && (Rd != 4'hF);
        pc_write = cond_exr && (Rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = cond_exr;
      end
      default: ;
    endcase
  end

  // Write strobes are cut combinationally so reset silences them immediately.
  assign PCWrite = pc_write && nRESET;
  assign IRWrite = ir_write && nRESET;
  assign RegW    = reg_w && nRESET;
  assign MemW    = mem_w && nRESET;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};
  assign Flags   = flags;
  assign State   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction model expands each instruction into
// its expected cycle sequence; a negedge process compares every cycle against it.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [3:0] Cond = 4'h0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'h00;
  logic [3:0] Rd = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, State;

  multicycle_ctrl dut (
    .CLK(CLK), .nRESET(nRESET), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW),
    .IRWrite(IRWrite), .RegW(RegW), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, aluc, imms, regsrc;
    logic [3:0] flg;
  } exp_t;

  exp_t       q[$];
  logic [3:0] mflags = 4'h0;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t ent(input int st, input logic pcw, adr, memw, irw, regw,
                               input logic [1:0] res, input logic srca,
                               input logic [1:0] srcb, aluc);
    exp_t e;
    e = '0;
    e.st = st[3:0];
    e.pcw = pcw; e.adr = adr; e.memw = memw; e.irw = irw; e.regw = regw;
    e.res = res; e.srca = srca; e.srcb = srcb; e.aluc = aluc;
    return e;
  endfunction

  // Expected behaviour of one instruction; stop_after>0 leaves it unfinished.
  task automatic run(input logic [31:0] instr, input logic [3:0] af, input int stop_after);
    exp_t seq[$];
    logic [1:0] op, aluc;
    logic ce, s;
    logic [3:0] cmd, rd;
    int n;
    op = instr[27:26];
    cmd = instr[24:21];
    s = instr[20];
    rd = instr[15:12];
    Cond = instr[31:28]; Op = op; Funct = instr[25:20]; Rd = rd; ALUFlags = af;
    ce = cond_ok(instr[31:28], mflags);
    aluc = (cmd == 4'b0010) ? 2'd1 : (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 : 2'd0;
    seq.push_back(ent(0, 1, 0, 0, 1, 0, 2'd2, 1, 2'd2, 2'd0));
    seq.push_back(ent(1, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0));
    foreach (seq[i]) seq[i].flg = mflags;
    case (op)
      2'b01: begin
        seq.push_back(ent(2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0));
        if (instr[20]) begin
          seq.push_back(ent(3, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0));
          seq.push_back(ent(4, 0, 0, 0, 0, ce, 2'd1, 0, 2'd0, 2'd0));
        end else
          seq.push_back(ent(5, 0, 1, ce, 0, 0, 2'd0, 0, 2'd0, 2'd0));
      end
      2'b00: begin
        seq.push_back(ent(instr[25] ? 7 : 6, 0, 0, 0, 0, 0, 2'd0, 0,
                          instr[25] ? 2'd1 : 2'd0, aluc));
        seq.push_back(ent(8, ce && rd == 4'hF, 0, 0, 0, ce && rd != 4'hF, 2'd0, 0, 2'd0, 2'd0));
      end
      2'b10: seq.push_back(ent(9, ce, 0, 0, 0, 0, 2'd2, 0, 2'd1, 2'd0));
      default: ;
    endcase
    for (int i = 2; i < seq.size(); i++) seq[i].flg = mflags;
    if (op == 2'b00 && s && ce) begin
      seq[3].flg = (aluc < 2) ? af : {af[3:2], mflags[1:0]};
      mflags = seq[3].flg;
    end
    foreach (seq[i]) begin
      seq[i].imms = op;
      seq[i].regsrc = {op == 2'b01, op == 2'b10};
      q.push_back(seq[i]);
    end
    n = (stop_after > 0) ? stop_after : seq.size();
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic hold_reset(input int cycles);
    exp_t e;
    e = ent(0, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0);
    e.imms = Op;
    e.regsrc = {Op == 2'b01, Op == 2'b10};
    repeat (cycles) q.push_back(e);
    repeat (cycles) @(posedge CLK);
    #1;
    nRESET = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {State, PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags};
      check($sformatf("cycle_state%0d", e.st), a, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge CLK);
    #1;
    hold_reset(2);
    check("le_model_pin", cond_ok(4'hD, 4'b0110), 1);
    run(32'hE5921004, 4'h0, 0);
    run(32'hE5821008, 4'h0, 0);
    run(32'hE2511000, 4'b0110, 0);
    check("subs_flags", Flags, 4'b0110);
    check("subs_flags_model", mflags, 4'b0110);
    run(32'hDA000000, 4'h0, 0);
    run(32'hE2511000, 4'b0000, 0);
    check("subs_zero_flags", Flags, 4'b0000);
    run(32'hDA000000, 4'h0, 0);
    run(32'h0391F0FF, 4'b1111, 0);
    check("orrseq_skipped_flags", Flags, 4'b0000);
    run(32'hE391F0FF, 4'b1011, 0);
    check("orrs_flags", Flags, 4'b1000);
    check("orrs_flags_model", mflags, 4'b1000);
    run(32'hEC000000, 4'b1111, 0);
    run(32'hE0110002, 4'b0111, 0);
    run(32'hE0310002, 4'b0011, 0);
    run(32'hF2911001, 4'b1111, 0);
    run(32'hE2511000, 4'b1010, 0);
    check("pre_reset_flags_model", mflags, 4'b1010);
    run(32'hE5821008, 4'h0, 3);
    check("memwr_before_reset", {State, MemW, AdrSrc}, {4'd5, 1'b1, 1'b1});
    nRESET = 1'b0;
    #1;
    check("memw_reset_drop", MemW, 0);
    check("state_reset", State, 0);
    check("flags_reset", Flags, 0);
    q.delete();
    mflags = 4'h0;
    hold_reset(2);
    run(32'hE5921004, 4'h0, 0);
    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
